ung_mc_skip: RTL and testbench

- Parametrised successor to the fixed 64-bit skip-ahead uniform number generator.
- N_CH independent Galois LFSR channels, each W bits wide. Each channel advances SKIP single steps per accepted output word.
- Adds runtime reseeding, a warm-up discard phase, a valid/ready output handshake with backpressure, and a word counter.
- Feeds the downstream noise and dither datapaths of the batch pipeline.

---
 rtl/ung_mc_skip.sv | 149 ++++++++++++++
 tb/tb_ung_mc_skip.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ung_mc_skip.sv
// ung_mc_skip: multi-channel skip-ahead uniform number generator.
//
// N_CH independent Galois LFSRs of W bits each. Every accepted advance
// moves each channel SKIP single steps in one clock. The unrolled skip
// function is purely combinational. After reset or a reseed, WARMUP
// advances are discarded before words are presented on the output port.
//
// Ports:
//   clk        - clock
//   rstn       - asynchronous active-low reset
//   en         - generation enable
//   seed_valid - reseed request (seed_ready is tied high, so it is always taken)
//   seed_ch    - target channel of the reseed
//   seed_data  - new seed; zero is mapped to 1 to avoid LFSR lockup
//   seed_ready - reseed accept (constant 1)
//   seed_err   - one-cycle pulse the cycle after a reseed names a missing channel
//   out_valid  - data_out holds a word not yet taken
//   out_ready  - consumer accepts the word
//   data_out   - channel c in bits [c*W +: W]
//   busy_warm  - FSM is in the warm-up phase (also serves as FSM state debug)
//   word_cnt   - number of completed output handshakes, wraps at 2^32
//
// Output handshake: a word transfers on any cycle with out_valid && out_ready.
// While out_valid is high and out_ready is low, data_out is held stable.
// out_valid is never dropped by en = 0; only a transfer or a valid reseed
// clears it.
module ung_mc_skip #(
    parameter int          W         = 64,
    parameter int          N_CH      = 4,
    parameter logic [63:0] POLY      = 64'hD800000000000000,
    parameter int          SKIP      = 11,
    parameter logic [63:0] SEED_BASE = 64'd5030521883283424767,
    parameter int          WARMUP    = 16,
    localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                seed_valid,
    input  logic [CH_W-1:0]     seed_ch,
    input  logic [W-1:0]        seed_data,
    output logic                seed_ready,
    output logic                seed_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_CH*W-1:0]   data_out,
    output logic                busy_warm,
    output logic [31:0]         word_cnt
);

    localparam logic [W-1:0] POLY_W = W'(POLY);
    localparam logic [W-1:0] BASE_W = W'(SEED_BASE);
    localparam logic [W-1:0] ONE_W  = W'(1);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam state_t ST_INIT = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

    // Single Galois step: shift right, fold the feedback mask in when the
    // bit shifted out was 1.
    function automatic logic [W-1:0] step1(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY_W : '0);
    endfunction

    function automatic logic [W-1:0] skip_f(input logic [W-1:0] s);
        logic [W-1:0] t;
        t = s;
        for (int i = 0; i < SKIP; i++) t = step1(t);
        return t;
    endfunction

    function automatic logic [W-1:0] reset_seed(input int c);
        logic [W-1:0] v;
        v = BASE_W + W'(c);
        if (v == '0) v = ONE_W;
        return v;
    endfunction

    state_t         fsm;
    logic [31:0]    warm_cnt;
    logic [W-1:0]   lfsr [N_CH];
    logic [W-1:0]   lfsr_nxt [N_CH];
    logic [N_CH*W-1:0] next_word;

    logic seed_ch_ok;
    logic seed_hit;
    logic xfer;
    logic advance;

    always_comb begin
        next_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            lfsr_nxt[c]          = skip_f(lfsr[c]);
            next_word[c*W +: W]  = lfsr_nxt[c];
        end
    end

    assign seed_ch_ok = (32'(seed_ch) < 32'(N_CH));
    assign seed_hit   = seed_valid && seed_ch_ok;
    assign xfer       = out_valid && out_ready;
    // Warm-up ignores the output port, since no word is ever pending there.
    assign advance    = en && !seed_valid &&
                        (fsm == ST_WARMUP || !out_valid || out_ready);

    assign seed_ready = 1'b1;
    assign busy_warm  = (fsm == ST_WARMUP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < N_CH; c++) lfsr[c] <= reset_seed(c);
            data_out  <= '0;
            out_valid <= 1'b0;
            word_cnt  <= '0;
            seed_err  <= 1'b0;
            fsm       <= ST_INIT;
            warm_cnt  <= 32'(WARMUP);
        end else begin
            seed_err <= seed_valid && !seed_ch_ok;
            if (seed_hit) begin
                // Reseed flushes the pending word without counting it.
                for (int c = 0; c < N_CH; c++) begin
                    if (32'(c) == 32'(seed_ch))
                        lfsr[c] <= (seed_data == '0) ? ONE_W : seed_data;
                end
                out_valid <= 1'b0;
                warm_cnt  <= 32'(WARMUP);
                fsm       <= ST_INIT;
            end else begin
                if (xfer) word_cnt <= word_cnt + 32'd1;
                if (advance) begin
                    for (int c = 0; c < N_CH; c++) lfsr[c] <= lfsr_nxt[c];
                    if (fsm == ST_RUN) begin
                        data_out  <= next_word;
                        out_valid <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt - 32'd1;
                        if (warm_cnt == 32'd1) fsm <= ST_RUN;
                    end
                end else if (xfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ung_mc_skip.sv
// Testbench for ung_mc_skip.
//
// Four instances share clock, reset, en, out_ready and seed_data:
//   dut_a : W=8 N_CH=2 POLY=B8 SKIP=1 WARMUP=0 SEED_BASE=1 (main stream)
//   dut_b : as dut_a with SKIP=2
//   dut_c : as dut_a with WARMUP=3
//   dut_d : as dut_a with N_CH=3 (2-bit seed_ch, so a missing channel exists)
// dut_a..c share seed_valid/seed_ch; dut_d has its own seed request inputs.
//
// Reference sequences (single step with mask B8):
//   01 -> B8 -> 5C -> 2E -> 17 -> B3 -> E1 -> C8
//   02 -> 01 -> B8 -> 5C -> 2E
//   03 -> B9 -> E4 -> 72
// data_out = {ch1, ch0} (ch0 in the low byte).
module tb_ung_mc_skip;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        out_ready;
    logic        seed_valid;
    logic        seed_ch;
    logic [7:0]  seed_data;
    logic        seed_valid_d;
    logic [1:0]  seed_ch_d;

    logic        ready_a, err_a, valid_a, busy_a;
    logic [15:0] data_a;
    logic [31:0] cnt_a;
    logic        ready_b, err_b, valid_b, busy_b;
    logic [15:0] data_b;
    logic [31:0] cnt_b;
    logic        ready_c, err_c, valid_c, busy_c;
    logic [15:0] data_c;
    logic [31:0] cnt_c;
    logic        ready_d, err_d, valid_d, busy_d;
    logic [23:0] data_d;
    logic [31:0] cnt_d;

    int n_tests = 0;
    int n_fail  = 0;

    ung_mc_skip #(.W(8), .N_CH(2), .POLY(64'hB8), .SKIP(1), .SEED_BASE(64'd1), .WARMUP(0)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .seed_valid(seed_valid), .seed_ch(seed_ch),
        .seed_data(seed_data), .seed_ready(ready_a), .seed_err(err_a), .out_valid(valid_a),
        .out_ready(out_ready), .data_out(data_a), .busy_warm(busy_a), .word_cnt(cnt_a));

    ung_mc_skip #(.W(8), .N_CH(2), .POLY(64'hB8), .SKIP(2), .SEED_BASE(64'd1), .WARMUP(0)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .seed_valid(seed_valid), .seed_ch(seed_ch),
        .seed_data(seed_data), .seed_ready(ready_b), .seed_err(err_b), .out_valid(valid_b),
        .out_ready(out_ready), .data_out(data_b), .busy_warm(busy_b), .word_cnt(cnt_b));

    ung_mc_skip #(.W(8), .N_CH(2), .POLY(64'hB8), .SKIP(1), .SEED_BASE(64'd1), .WARMUP(3)) dut_c (
        .clk(clk), .rstn(rstn), .en(en), .seed_valid(seed_valid), .seed_ch(seed_ch),
        .seed_data(seed_data), .seed_ready(ready_c), .seed_err(err_c), .out_valid(valid_c),
        .out_ready(out_ready), .data_out(data_c), .busy_warm(busy_c), .word_cnt(cnt_c));

    ung_mc_skip #(.W(8), .N_CH(3), .POLY(64'hB8), .SKIP(1), .SEED_BASE(64'd1), .WARMUP(0)) dut_d (
        .clk(clk), .rstn(rstn), .en(en), .seed_valid(seed_valid_d), .seed_ch(seed_ch_d),
        .seed_data(seed_data), .seed_ready(ready_d), .seed_err(err_d), .out_valid(valid_d),
        .out_ready(out_ready), .data_out(data_d), .busy_warm(busy_d), .word_cnt(cnt_d));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic e, input logic r, input logic sv, input logic sc,
                         input logic [7:0] sd);
        en         = e;
        out_ready  = r;
        seed_valid = sv;
        seed_ch    = sc;
        seed_data  = sd;
    endtask

    // ---------------- vector table for dut_a ----------------
    typedef struct {
        logic        en;
        logic        rdy;
        logic        sv;
        logic        sch;
        logic [7:0]  sdata;
        logic        exp_v;
        logic [15:0] exp_d;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // first word, then 5 cycles of backpressure hold it
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h01B8, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h01B8, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h01B8, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h01B8, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h01B8, 32'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h01B8, 32'd0};
        // release: next word, no states skipped
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'hB85C, 32'd1};
        // en=0 keeps the pending word
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hB85C, 32'd1};
        // transfer without advance drops valid, data held
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'hB85C, 32'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'hB85C, 32'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h5C2E, 32'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h2E17, 32'd3};
        // reseed ch1 with 0 while a word is pending and ready: dropped, not counted
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 16'h2E17, 32'd3};
        // ch1 restarts from 01 -> B8, ch0 continues 17 -> B3
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'hB8B3, 32'd3};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h5CE1, 32'd4};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h2EC8, 32'd5};
    end

    // ---------------- main sequence ----------------
    initial begin
        rstn         = 1'b0;
        seed_valid_d = 1'b0;
        seed_ch_d    = 2'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // reset values
        check("rst valid_a", 32'(valid_a), 32'd0);
        check("rst data_a", 32'(data_a), 32'h0);
        check("rst cnt_a", cnt_a, 32'd0);
        check("rst err_a", 32'(err_a), 32'd0);
        check("rst busy_a", 32'(busy_a), 32'd0);
        check("rst seed_ready_a", 32'(ready_a), 32'd1);
        check("rst busy_c", 32'(busy_c), 32'd1);
        check("rst valid_c", 32'(valid_c), 32'd0);

        // free-running stream after reset
        rstn = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("s1 valid_a", 32'(valid_a), 32'd1);
        check("s1 data_a", 32'(data_a), 32'h01B8);
        check("s1 cnt_a", cnt_a, 32'd0);
        check("s1 data_b", 32'(data_b), 32'hB85C);
        check("s1 valid_c", 32'(valid_c), 32'd0);
        check("s1 busy_c", 32'(busy_c), 32'd1);
        @(negedge clk);
        check("s2 data_a", 32'(data_a), 32'hB85C);
        check("s2 cnt_a", cnt_a, 32'd1);
        check("s2 data_b", 32'(data_b), 32'h2E17);
        check("s2 cnt_b", cnt_b, 32'd1);
        check("s2 valid_c", 32'(valid_c), 32'd0);
        check("s2 busy_c", 32'(busy_c), 32'd1);
        @(negedge clk);
        check("s3 data_a", 32'(data_a), 32'h5C2E);
        check("s3 cnt_a", cnt_a, 32'd2);
        check("s3 data_b", 32'(data_b), 32'hB3E1);
        check("s3 valid_c", 32'(valid_c), 32'd0);
        check("s3 busy_c", 32'(busy_c), 32'd0);
        @(negedge clk);
        check("s4 data_a", 32'(data_a), 32'h2E17);
        check("s4 cnt_a", cnt_a, 32'd3);
        // warm-up discarded 3 advances: ch0 17, ch1 2E
        check("s4 valid_c", 32'(valid_c), 32'd1);
        check("s4 data_c", 32'(data_c), 32'h2E17);
        check("s4 cnt_c", cnt_c, 32'd0);

        // asynchronous reset mid-stream, checked before any clock edge
        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        check("arst valid_a", 32'(valid_a), 32'd0);
        check("arst data_a", 32'(data_a), 32'h0);
        check("arst cnt_a", cnt_a, 32'd0);
        check("arst busy_c", 32'(busy_c), 32'd1);
        @(negedge clk);

        // table replays the reset sequence on dut_a
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].sv, vecs[i].sch, vecs[i].sdata);
            @(negedge clk);
            check($sformatf("vec%0d valid", i), 32'(valid_a), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d data", i), 32'(data_a), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d cnt", i), cnt_a, vecs[i].exp_cnt);
            check($sformatf("vec%0d err", i), 32'(err_a), 32'd0);
        end

        // missing-channel reseed on dut_d (N_CH=3, seed_ch=3)
        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("d1 data_d", 32'(data_d), 32'hB901B8);
        check("d1 cnt_d", cnt_d, 32'd0);
        @(negedge clk);
        check("d2 data_d", 32'(data_d), 32'hE4B85C);
        check("d2 cnt_d", cnt_d, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        seed_valid_d = 1'b1;
        seed_ch_d    = 2'd3;
        @(negedge clk);
        check("d3 err_d", 32'(err_d), 32'd1);
        check("d3 valid_d", 32'(valid_d), 32'd1);
        check("d3 data_d", 32'(data_d), 32'hE4B85C);
        check("d3 cnt_d", cnt_d, 32'd1);
        seed_valid_d = 1'b0;
        seed_ch_d    = 2'd0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("d4 err_d", 32'(err_d), 32'd0);
        check("d4 data_d", 32'(data_d), 32'h725C2E);
        check("d4 cnt_d", cnt_d, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
